// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
// Bundles the hazard unit's pipeline status inputs, latch controls and
// performance counters into one interface.
//   master : the pipeline side. It drives the status signals and receives
//            the controls and counters.
//   slave  : the hazard unit. It reads the status signals and drives the
//            controls and counters.
// Status  : ihit, dhit, ex_memRd, ex_rt, id_rs, id_rt, id_uses_rt,
//           mem_ren, mem_wen, mem_pcsrc, mem_halt, flush_done
// Control : pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//           ifid_flush, idex_flush, exmem_flush, dcache_flush, halt
// Counters: stall_cycles, flush_count, lu_count (CNT_W bits each)
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
  parameter int CNT_W = 16
) ();
  logic             ihit;
  logic             dhit;
  logic             ex_memRd;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             mem_ren;
  logic             mem_wen;
  logic             mem_pcsrc;
  logic             mem_halt;
  logic             flush_done;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             dcache_flush;
  logic             halt;

  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] lu_count;

  modport master (
    output ihit, dhit, ex_memRd, ex_rt, id_rs, id_rt, id_uses_rt,
           mem_ren, mem_wen, mem_pcsrc, mem_halt, flush_done,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, dcache_flush, halt,
           stall_cycles, flush_count, lu_count
  );

  modport slave (
    input  ihit, dhit, ex_memRd, ex_rt, id_rs, id_rt, id_uses_rt,
           mem_ren, mem_wen, mem_pcsrc, mem_halt, flush_done,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, dcache_flush, halt,
           stall_cycles, flush_count, lu_count
  );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Stall and flush controller for the 5-stage core. It covers the hazards
// that forwarding cannot resolve: load-use, taken branch or jump, instruction
// and data memory wait, and the halt drain (RUN -> DRAIN -> HALTED).
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset; while low, every output reads 0
//   hz    : hazard_unit_if.slave (status in; latch controls and counters out)
// Enable and flush outputs are combinational from the state and inputs.
// Optional feature: define HAZARD_PERF_EN to build the performance counters.
// Without it, the counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  hazard_unit_if.slave  hz
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;

  logic memwait_s;
  logic lu_s;
  logic branch_s;
  logic bubble_s;

  logic pc_en_s;
  logic ifid_en_s;
  logic idex_en_s;
  logic exmem_en_s;
  logic memwb_en_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic dcache_flush_s;
  logic halt_s;

  // Hazard detection terms. A load to r0 never produces a real dependency.
  always_comb begin
    memwait_s = (hz.mem_ren | hz.mem_wen) & ~hz.dhit;
    lu_s      = hz.ex_memRd & (hz.ex_rt != 5'd0) &
                ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
  end

  // Next state and the priority-ordered latch controls.
  always_comb begin
    state_nxt_s    = state_r;
    pc_en_s        = 1'b0;
    ifid_en_s      = 1'b0;
    idex_en_s      = 1'b0;
    exmem_en_s     = 1'b0;
    memwb_en_s     = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_flush_s   = 1'b0;
    exmem_flush_s  = 1'b0;
    dcache_flush_s = 1'b0;
    halt_s         = 1'b0;
    branch_s       = 1'b0;
    bubble_s       = 1'b0;
    case (state_r)
      RUN: begin
        if (memwait_s) begin
          // Full freeze. Every control keeps its default of 0.
          state_nxt_s = RUN;
        end else if (hz.mem_halt) begin
          // The pipeline freezes behind the halt while the dcache drains.
          // Halt takes priority over a branch in the same slot.
          state_nxt_s = DRAIN;
        end else if (hz.mem_pcsrc) begin
          // Squash IF, ID and EX. The branch target is loaded even if
          // ihit is low, because the fetched word is discarded anyway.
          pc_en_s       = 1'b1;
          ifid_en_s     = 1'b1;
          idex_en_s     = 1'b1;
          exmem_en_s    = 1'b1;
          memwb_en_s    = 1'b1;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
          branch_s      = 1'b1;
        end else if (lu_s) begin
          // Hold IF and ID and insert one bubble into EX. The load then
          // moves to MEM, so the stall clears itself after one cycle.
          idex_en_s    = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
          idex_flush_s = 1'b1;
          bubble_s     = 1'b1;
        end else if (!hz.ihit) begin
          // Fetch still pending: keep PC and send a bubble down from IF/ID.
          ifid_en_s    = 1'b1;
          idex_en_s    = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
          ifid_flush_s = 1'b1;
        end else begin
          pc_en_s    = 1'b1;
          ifid_en_s  = 1'b1;
          idex_en_s  = 1'b1;
          exmem_en_s = 1'b1;
          memwb_en_s = 1'b1;
        end
      end
      DRAIN: begin
        dcache_flush_s = 1'b1;
        if (hz.flush_done) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED: begin
        halt_s      = 1'b1;
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // nRST gates every output to 0 at once. This also drops a pending
  // dcache_flush as soon as reset is asserted.
  assign hz.pc_en        = nRST & pc_en_s;
  assign hz.ifid_en      = nRST & ifid_en_s;
  assign hz.idex_en      = nRST & idex_en_s;
  assign hz.exmem_en     = nRST & exmem_en_s;
  assign hz.memwb_en     = nRST & memwb_en_s;
  assign hz.ifid_flush   = nRST & ifid_flush_s;
  assign hz.idex_flush   = nRST & idex_flush_s;
  assign hz.exmem_flush  = nRST & exmem_flush_s;
  assign hz.dcache_flush = nRST & dcache_flush_s;
  assign hz.halt         = nRST & halt_s;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_count_r;
  logic [CNT_W-1:0] lu_count_r;
  logic             run_s;

  assign run_s = (state_r == RUN);

  // Performance counters. They advance only in RUN and wrap naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_count_r  <= {CNT_W{1'b0}};
      lu_count_r     <= {CNT_W{1'b0}};
    end else if (run_s) begin
      if (!pc_en_s && !hz.mem_halt) begin
        stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (branch_s) begin
        flush_count_r <= flush_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bubble_s) begin
        lu_count_r <= lu_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hz.stall_cycles = nRST ? stall_cycles_r : {CNT_W{1'b0}};
  assign hz.flush_count  = nRST ? flush_count_r  : {CNT_W{1'b0}};
  assign hz.lu_count     = nRST ? lu_count_r     : {CNT_W{1'b0}};
`else
  logic unused_s;

  // The branch and bubble markers only feed the counters.
  assign unused_s = branch_s ^ bubble_s;

  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_count  = {CNT_W{1'b0}};
  assign hz.lu_count     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Drives hazard_unit with directed and randomized stimulus. Each cycle the
// driver predicts the outputs from a rule-level reference model and queues
// the prediction. A monitor on the falling clock edge pops each prediction
// and compares it with what the DUT shows. Counter expectations follow
// HAZARD_PERF_EN, so the bench matches either build.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic nRST;

  hazard_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Output vector layout:
  // [9] pc_en [8] ifid_en [7] idex_en [6] exmem_en [5] memwb_en
  // [4] ifid_flush [3] idex_flush [2] exmem_flush [1] dcache_flush [0] halt
  typedef struct {
    logic [9:0]       val;
    logic [9:0]       mask;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] lc;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  bit               m_drain;
  bit               m_halted;
  logic [CNT_W-1:0] m_sc, m_fc, m_lc;

  // Monitor: compares the DUT against the oldest queued prediction.
  always @(negedge CLK) begin
    exp_t       e;
    logic [9:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
             bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.dcache_flush, bus.halt};
      checks++;
      if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s ctrl got=%b want=%b mask=%b t=%0t", e.tag, act, e.val, e.mask, $time);
      end
      checks++;
      if ({bus.stall_cycles, bus.flush_count, bus.lu_count} !== {e.sc, e.fc, e.lc}) begin
        errors++;
        $display("FAIL %s counters got=%0d/%0d/%0d want=%0d/%0d/%0d t=%0t", e.tag,
                 bus.stall_cycles, bus.flush_count, bus.lu_count, e.sc, e.fc, e.lc, $time);
      end
    end
  end

  task automatic model_reset();
    m_drain  = 1'b0;
    m_halted = 1'b0;
    m_sc     = '0;
    m_fc     = '0;
    m_lc     = '0;
  endtask

  // Holds nRST low for n cycles with random inputs. Everything must read 0.
  task automatic rst_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      nRST           = 1'b0;
      bus.ihit       = 1'($urandom);
      bus.dhit       = 1'($urandom);
      bus.ex_memRd   = 1'($urandom);
      bus.ex_rt      = 5'($urandom);
      bus.id_rs      = 5'($urandom);
      bus.id_rt      = 5'($urandom);
      bus.id_uses_rt = 1'($urandom);
      bus.mem_ren    = 1'($urandom);
      bus.mem_wen    = 1'($urandom);
      bus.mem_pcsrc  = 1'($urandom);
      bus.mem_halt   = 1'($urandom);
      bus.flush_done = 1'($urandom);
      model_reset();
      e.val  = 10'b0;
      e.mask = 10'h3FF;
      e.sc   = '0;
      e.fc   = '0;
      e.lc   = '0;
      e.tag  = "reset";
      sb.push_back(e);
    end
  endtask

  // Applies one cycle of inputs, queues the prediction and advances the model.
  task automatic step(input string tag, input bit ih, input bit dh, input bit exrd,
                      input logic [4:0] ert, input logic [4:0] irs, input logic [4:0] irt,
                      input bit urt, input bit mren, input bit mwen, input bit pcs,
                      input bit mh, input bit fd);
    exp_t e;
    bit   mw;
    bit   lu;
    @(posedge CLK);
    #1;
    nRST           = 1'b1;
    bus.ihit       = ih;
    bus.dhit       = dh;
    bus.ex_memRd   = exrd;
    bus.ex_rt      = ert;
    bus.id_rs      = irs;
    bus.id_rt      = irt;
    bus.id_uses_rt = urt;
    bus.mem_ren    = mren;
    bus.mem_wen    = mwen;
    bus.mem_pcsrc  = pcs;
    bus.mem_halt   = mh;
    bus.flush_done = fd;

    mw = (mren || mwen) && !dh;
    lu = exrd && (ert != 5'd0) && ((ert == irs) || (urt && (ert == irt)));
    e.tag  = tag;
    e.mask = 10'h3FF;
`ifdef HAZARD_PERF_EN
    e.sc = m_sc;
    e.fc = m_fc;
    e.lc = m_lc;
`else
    e.sc = '0;
    e.fc = '0;
    e.lc = '0;
`endif
    if (m_halted) begin
      e.val = 10'b00000_000_0_1;
    end else if (m_drain) begin
      e.val = 10'b00000_000_1_0;
      if (fd) begin
        m_drain  = 1'b0;
        m_halted = 1'b1;
      end
    end else begin
      if (mw || mh) begin
        e.val = 10'b00000_000_0_0;
      end else if (pcs) begin
        // Enables on the flushed latches do not matter.
        e.val  = 10'b1_000_1_111_0_0;
        e.mask = 10'b1_000_1_111_1_1;
        m_fc   = m_fc + 1'b1;
      end else if (lu) begin
        // idex_en does not matter: idex_flush overrides it.
        e.val  = 10'b0_0_0_1_1_0_1_0_0_0;
        e.mask = 10'b1_1_0_1_1_1_1_1_1_1;
        m_lc   = m_lc + 1'b1;
      end else if (!ih) begin
        e.val = 10'b0_1111_1_0_0_0_0;
      end else begin
        e.val = 10'b11111_000_0_0;
      end
      if (!e.val[9] && !mh) m_sc = m_sc + 1'b1;
      if (mh && !mw) m_drain = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(tag, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_step(input string tag);
    step(tag, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
         $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
  endtask

  initial begin
    nRST           = 1'b0;
    bus.ihit       = 1'b0;
    bus.dhit       = 1'b0;
    bus.ex_memRd   = 1'b0;
    bus.ex_rt      = 5'd0;
    bus.id_rs      = 5'd0;
    bus.id_rt      = 5'd0;
    bus.id_uses_rt = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_pcsrc  = 1'b0;
    bus.mem_halt   = 1'b0;
    bus.flush_done = 1'b0;
    model_reset();
    rst_cycles(2);

    // Load-use on rs, then the stall clears.
    step("lu_r5", 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0);
    step("lu_after", 1, 1, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0);
    // r0 never stalls. rt only counts when the ID instruction reads it.
    step("lu_r0", 1, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
    step("no_lu_rt", 1, 1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0, 0);
    step("lu_rt", 1, 1, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 0, 0);
    // Data wait combined with a pending branch.
    repeat (4) step("dwait_br", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 0, 0);
    step("br_dhit", 0, 1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1, 0, 0);
    // Fetch miss while a load-use hazard is present.
    step("ihit_lu", 0, 1, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0, 0, 0, 0);
    step("ihit_lo", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    step("dwait_w", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
    // Halt drain, then the halted state under random inputs.
    step("halt", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    repeat (10) idle("drain");
    step("flush_done", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
    repeat (50) rand_step("halted");
    rst_cycles(1);
    idle("run_again");
    // Reset in the middle of a drain.
    step("halt2", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);
    repeat (3) idle("drain2");
    rst_cycles(2);
    idle("post_rst");
    step("fd_in_run", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);

    // Random traffic. Leave HALTED now and then with a reset.
    for (int i = 0; i < 1500; i++) begin
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        rst_cycles(1);
      end else begin
        rand_step("random");
      end
    end

    @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_queue got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the 5-stage core. It sits directly upstream of the forwarding logic: it drives the enable/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches that produce the `mem_rd`/`wb_rd`/`memRegWr` values the forward unit compares. It handles the hazards forwarding cannot cover: load-use, taken branch/jump, instruction and data memory wait, and halt drain. The halt drain is a registered FSM, and optional performance counters can be compiled in.

## Interface
- `CNT_W`, 16: width of each performance counter.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `ex_memRd` in 1: instruction in EX is a load.
- `ex_rt` in 5: load destination register in EX.
- `id_rs`, `id_rt` in 5: source registers in ID.
- `id_uses_rt` in 1: ID instruction reads rt as a source.
- `mem_ren`, `mem_wen` in 1: MEM-stage data read/write request.
- `mem_pcsrc` in 1: taken branch or jump resolved in MEM.
- `mem_halt` in 1: halt instruction in MEM.
- `flush_done` in 1: dcache writeback complete.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: load a bubble on the next edge; a flush overrides its enable.
- `dcache_flush` out 1: request dcache writeback.
- `halt` out 1: core halted (sticky).
- `stall_cycles`, `flush_count`, `lu_count` out `CNT_W`: performance counters.

## Operation
- FSM states:
  - `RUN`: normal operation.
  - `DRAIN`: halt reached MEM; waiting for the dcache writeback.
  - `HALTED`: terminal state.
- Transitions:
  - `RUN`→`DRAIN` when `mem_halt` && !`memwait`.
  - `DRAIN`→`HALTED` when `flush_done`.
  - `HALTED` holds until `nRST` is asserted.
- Definitions:
  - `memwait` = (`mem_ren` | `mem_wen`) & !`dhit`.
  - `lu` = `ex_memRd` & (`ex_rt` != 0) & (`ex_rt` == `id_rs` | (`id_uses_rt` & `ex_rt` == `id_rt`)).
- `RUN` outputs, first matching rule wins:
  1. `memwait`: all enables 0, all flushes 0 (full freeze).
  2. `mem_halt`: all enables 0 (pipeline frozen; `DRAIN` starts next cycle).
  3. `mem_pcsrc`:
     - `pc_en`=1; `ifid_flush`, `idex_flush` and `exmem_flush` all =1; `memwb_en`=1.
     - Branch wins over load-use and over `ihit` low: the fetched word is discarded.
  4. `lu`:
     - `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1.
     - The bubble lasts exactly one cycle, because the load then leaves EX.
  5. !`ihit`: `pc_en`=0, `ifid_flush`=1, all other enables 1.
  6. Otherwise: all enables 1, flushes 0.
- `DRAIN`: all enables 0, `dcache_flush`=1, flushes 0.
- `HALTED`: all enables 0, `dcache_flush`=0, `halt`=1.
- Register 0 never triggers a load-use stall.

## Timing
- Enable and flush outputs are combinational from the current state and inputs; they act on the next rising `CLK`.
- The state register and counters update on the rising `CLK`.
- `halt` is decoded from state: it rises one cycle after the `flush_done` edge sample.
- Reset (`nRST` low, asynchronous):
  - State → `RUN`; counters → 0.
  - While `nRST` is low, every output is forced to 0, regardless of the other inputs.
- Reset mid-`DRAIN` or in `HALTED` returns the block to `RUN`; the pending `dcache_flush` drops immediately.
- `flush_done` seen in `RUN` is ignored.
- `mem_halt` and `mem_pcsrc` are never both high (same stage slot); if both are high, halt wins.
- Stall latency:
  - Load-use: 1 cycle.
  - Branch: penalty of 3 squashed instructions.
  - Memory wait: lasts exactly as many cycles as `dhit` stays low.

## Configuration
- `HAZARD_PERF_EN` defined: counters are implemented, each wraps at 2^`CNT_W`:
  - `stall_cycles` increments every `RUN` cycle in which `pc_en`=0 and !`mem_halt`.
  - `flush_count` increments on each branch flush cycle.
  - `lu_count` increments on each load-use bubble.
  - Counters freeze in `DRAIN` and `HALTED`.
- `HAZARD_PERF_EN` undefined: the counter ports remain and are tied to 0, with no counter flops.

## Test plan
- Load to r5 in EX, ID add reads r5 as rs, `ihit`=1 → one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1; next cycle all enables 1; `lu_count`=1.
- Load to r0 in EX, ID reads r0 → no stall; load to r7, ID `id_uses_rt`=0 and `id_rt`=7 → no stall.
- `mem_ren`=1, `dhit`=0 for 4 cycles, together with `mem_pcsrc`=1 → 4 cycles of all enables 0; on the `dhit` cycle the three flushes assert; `flush_count`=1, `stall_cycles`=4.
- `mem_halt`=1 → `DRAIN` with `dcache_flush`=1 held for 10 cycles; `flush_done` pulse → `halt`=1 next cycle, and stays 1 with all enables 0 for 50 cycles.
- Assert `nRST` low mid-`DRAIN` → all outputs 0 immediately; after release, state `RUN`, counters 0, `halt`=0.
- `ihit`=0 and `lu` together → `ifid_en`=0 (hold, no `ifid_flush`), `idex_flush`=1.
